muldiv_sequencer: RTL and testbench

Multi-cycle sequencer for the RV32M multiply/divide operations in the EX stage. It accepts one M-extension operation at a time and runs the multiply in a single registered cycle. Divide and remainder run as a 1-bit-per-cycle restoring iteration. While the operation is in flight it asserts BUSY so the pipeline can stall, and it returns the result with a one-cycle DONE pulse.

---
 rtl/muldiv_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Multi-cycle RV32M multiply/divide sequencer for the EX stage. It accepts one
// operation at a time. The multiply finishes in one registered cycle. Divide
// and remainder use a restoring iteration that produces one quotient bit per
// cycle. While an accepted operation is in flight, o_busy is high. The result
// is returned with a one-cycle o_done pulse.
//
// Ports
//   clk        in   1     clock, rising edge
//   rst_n      in   1     asynchronous active-low reset
//   i_start    in   1     request, sampled only in IDLE or FIN
//   i_funct3   in   3     000 MUL 001 MULH 010 MULHSU 011 MULHU
//                         100 DIV 101 DIVU 110 REM 111 REMU
//   i_data1    in   XLEN  rs1 (multiplicand / dividend)
//   i_data2    in   XLEN  rs2 (multiplier / divisor)
//   i_flush    in   1     synchronous abort, wins over i_start
//   o_busy     out  1     high while an accepted op has not completed
//   o_done     out  1     one-cycle pulse when o_result is valid
//   o_result   out  XLEN  holds its value until the next completion
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_start,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_data1,
   input  logic [XLEN-1:0] i_data2,
   input  logic            i_flush,
   output logic            o_busy,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_FIN  = 2'd3
   } state_t;

   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = '1;
   localparam logic [5:0]      LAST_CNT = 6'(XLEN-1);

   state_t            r_state, w_state_nx;
   logic              r_busy, w_busy_nx;
   logic              r_done, w_done_nx;
   logic [XLEN-1:0]   r_result, w_result_nx;

   // Latched operation and operands
   logic [2:0]        r_op;
   logic [XLEN-1:0]   r_a, r_b;

   // Divider datapath. r_quo doubles as the dividend shift register: its MSB
   // is shifted into the partial remainder while the new quotient bit enters
   // at the LSB.
   logic [XLEN-1:0]   r_rem, r_quo, r_dvs;
   logic [5:0]        r_cnt;
   logic              r_init;   // first DIV cycle loads the operand magnitudes

   // ---------------------------------------------------------------- accept
   logic            w_accept;
   logic            w_in_signed, w_in_rem, w_in_dz, w_in_ovf;
   logic [XLEN-1:0] w_special;

   assign w_accept    = i_start && !i_flush && (r_state == S_IDLE || r_state == S_FIN);
   assign w_in_signed = ~i_funct3[0];
   assign w_in_rem    = i_funct3[1];
   assign w_in_dz     = (i_data2 == '0);
   assign w_in_ovf    = w_in_signed && (i_data1 == MIN_NEG) && (i_data2 == ALL_ONES);
   // Divide by zero returns all-ones / dividend; overflow returns MIN / 0.
   assign w_special   = w_in_dz ? (w_in_rem ? i_data1 : ALL_ONES)
                                : (w_in_rem ? '0 : MIN_NEG);

   // -------------------------------------------------------------- multiply
   // Operands are sign- or zero-extended to 2*XLEN; the low 2*XLEN bits of
   // the product are then exact for every signedness combination.
   logic                w_ma_s, w_mb_s;
   logic [2*XLEN-1:0]   w_ma, w_mb, w_prod;
   logic [XLEN-1:0]     w_mul_res;

   assign w_ma_s    = (r_op[1:0] != 2'b11) && r_a[XLEN-1];
   assign w_mb_s    = !r_op[1] && r_b[XLEN-1];
   assign w_ma      = {{XLEN{w_ma_s}}, r_a};
   assign w_mb      = {{XLEN{w_mb_s}}, r_b};
   assign w_prod    = w_ma * w_mb;
   assign w_mul_res = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

   // ---------------------------------------------------------------- divide
   logic            w_signed, w_a_neg, w_b_neg;
   logic [XLEN-1:0] w_abs_a, w_abs_b;
   logic [XLEN:0]   w_rem_sh, w_diff;
   logic            w_ge;
   logic [XLEN-1:0] w_rem_nx, w_quo_nx, w_q_fix, w_r_fix, w_div_res;

   assign w_signed = ~r_op[0];
   assign w_a_neg  = w_signed && r_a[XLEN-1];
   assign w_b_neg  = w_signed && r_b[XLEN-1];
   assign w_abs_a  = w_a_neg ? (~r_a + 1'b1) : r_a;
   assign w_abs_b  = w_b_neg ? (~r_b + 1'b1) : r_b;

   assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
   assign w_diff   = w_rem_sh - {1'b0, r_dvs};
   assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
   assign w_rem_nx = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
   assign w_quo_nx = {r_quo[XLEN-2:0], w_ge};

   // Quotient is negative when the signs differ; remainder follows dividend.
   assign w_q_fix   = (w_a_neg ^ w_b_neg) ? (~w_quo_nx + 1'b1) : w_quo_nx;
   assign w_r_fix   = w_a_neg ? (~w_rem_nx + 1'b1) : w_rem_nx;
   assign w_div_res = r_op[1] ? w_r_fix : w_q_fix;

   // ------------------------------------------------------ next state logic
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a signal unassigned and infer a latch.
      w_state_nx  = r_state;
      w_busy_nx   = 1'b0;
      w_done_nx   = 1'b0;
      w_result_nx = r_result;

      unique case (r_state)
         S_IDLE, S_FIN: begin
            w_state_nx = S_IDLE;
            if (w_accept) begin
               if (!i_funct3[2]) begin
                  w_state_nx = S_MUL;
                  w_busy_nx  = 1'b1;
               end else if (w_in_dz || w_in_ovf) begin
                  w_state_nx  = S_FIN;
                  w_done_nx   = 1'b1;
                  w_result_nx = w_special;
               end else begin
                  w_state_nx = S_DIV;
                  w_busy_nx  = 1'b1;
               end
            end
         end
         S_MUL: begin
            w_state_nx  = S_FIN;
            w_done_nx   = 1'b1;
            w_result_nx = w_mul_res;
         end
         S_DIV: begin
            w_busy_nx = 1'b1;
            if (!r_init && r_cnt == LAST_CNT) begin
               w_state_nx  = S_FIN;
               w_busy_nx   = 1'b0;
               w_done_nx   = 1'b1;
               w_result_nx = w_div_res;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase

      if (i_flush) begin
         w_state_nx  = S_IDLE;
         w_busy_nx   = 1'b0;
         w_done_nx   = 1'b0;
         w_result_nx = r_result;
      end
   end

   // --------------------------------------------------------- state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         r_state  <= w_state_nx;
         r_busy   <= w_busy_nx;
         r_done   <= w_done_nx;
         r_result <= w_result_nx;
      end
   end

   // ------------------------------------------------------- datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op   <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_rem  <= '0;
         r_quo  <= '0;
         r_dvs  <= '0;
         r_cnt  <= '0;
         r_init <= 1'b0;
      end else if (w_accept) begin
         r_op   <= i_funct3;
         r_a    <= i_data1;
         r_b    <= i_data2;
         r_cnt  <= '0;
         r_init <= 1'b1;
      end else if (r_state == S_DIV && !i_flush) begin
         if (r_init) begin
            r_init <= 1'b0;
            r_rem  <= '0;
            r_quo  <= w_abs_a;
            r_dvs  <= w_abs_b;
         end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + 6'd1;
         end
      end
   end

   assign o_busy   = r_busy;
   assign o_done   = r_done;
   assign o_result = r_result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Directed self-checking bench for muldiv_sequencer. Expected results and
// latencies are hand-computed constants. Outputs are sampled on the falling
// clock edge, and inputs are driven on the falling edge.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] data1 = '0;
   logic [31:0] data2 = '0;
   logic        flush = 1'b0;
   logic        busy, done;
   logic [31:0] result;

   int n_checks = 0;
   int n_errors = 0;
   int lat, busy_cnt;
   logic seen;

   localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHU = 3'b011,
                          F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110,
                          F_REMU = 3'b111;

   always #5 clk = ~clk;

   muldiv_sequencer #(.XLEN(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_start  (start),
      .i_funct3 (funct3),
      .i_data1  (data1),
      .i_data2  (data2),
      .i_flush  (flush),
      .o_busy   (busy),
      .o_done   (done),
      .o_result (result)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Count falling edges after the accepting edge until DONE, bounded.
   task automatic wait_done();
      lat = 0; busy_cnt = 0; seen = 1'b0;
      while (!seen && lat < 100) begin
         @(negedge clk);
         lat++;
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) seen = 1'b1;
         if (busy === 1'b1 && done === 1'b1) check("busy_and_done_overlap", 32'd1, 32'd0);
      end
      check("done_seen", {31'd0, seen}, 32'd1);
   endtask

   // Issue one op for a single cycle, wait for DONE, check result and timing.
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, input int exp_busy);
      @(negedge clk);
      start = 1'b1; funct3 = f3; data1 = a; data2 = b;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done();
      check({tag, "_result"}, result, exp_res);
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      // Reset state
      #2;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_result", result, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Multiply
      run_op("mul_7_m3", F_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, 1);
      run_op("mulh_min_min", F_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, 1);

      // Normal divide
      run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14, 34, 33);
      run_op("remu_100_7", F_REMU, 32'd100, 32'd7, 32'd2, 34, 33);
      run_op("div_m100_7", F_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, 33);
      run_op("rem_m100_7", F_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34, 33);

      // Divide by zero and overflow
      run_op("div_5_0", F_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
      run_op("remu_5_0", F_REMU, 32'd5, 32'd0, 32'd5, 1, 0);
      run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
      run_op("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);

      // Flush on the 10th DIV cycle; prior result is 0 from rem_ovf, so make
      // it distinctive first.
      run_op("mul_pre_flush", F_MUL, 32'd11, 32'd3, 32'd33, 2, 1);
      @(negedge clk);
      start = 1'b1; funct3 = F_DIVU; data1 = 32'd100; data2 = 32'd7;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 10; i++) @(negedge clk);
      check("flush_busy_before", {31'd0, busy}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy_after", {31'd0, busy}, 32'd0);
      check("flush_done_after", {31'd0, done}, 32'd0);
      check("flush_result_kept", result, 32'd33);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      end
      check("flush_no_late_done", {31'd0, seen}, 32'd0);
      check("flush_result_still", result, 32'd33);
      run_op("mul_6_7", F_MUL, 32'd6, 32'd7, 32'd42, 2, 1);

      // Back-to-back with START held: MULHU 3*5 then DIVU 9/2
      @(negedge clk);
      start = 1'b1; funct3 = F_MULHU; data1 = 32'd3; data2 = 32'd5;
      @(posedge clk);
      #1 funct3 = F_DIVU; data1 = 32'd9; data2 = 32'd2;
      @(negedge clk);
      check("b2b_busy_mul", {31'd0, busy}, 32'd1);
      check("b2b_done_mul_early", {31'd0, done}, 32'd0);
      @(negedge clk);
      check("b2b_done_first", {31'd0, done}, 32'd1);
      check("b2b_busy_in_fin", {31'd0, busy}, 32'd0);
      check("b2b_result_first", result, 32'd0);
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0; busy_cnt = 0; seen = 1'b0;
      while (!seen && lat < 100) begin
         @(negedge clk);
         lat++;
         if (busy === 1'b1) busy_cnt++;
         if (done === 1'b1) seen = 1'b1;
         if (busy === 1'b1 && done === 1'b1) check("b2b_overlap", 32'd1, 32'd0);
         // A START pulse during BUSY must be ignored.
         if (lat == 5) begin
            start = 1'b1; funct3 = F_MUL; data1 = 32'd2; data2 = 32'd2;
         end else begin
            start = 1'b0;
         end
      end
      check("b2b_done_second", {31'd0, seen}, 32'd1);
      check("b2b_result_second", result, 32'd4);
      check("b2b_latency_second", 32'(lat), 32'd34);
      check("b2b_busy_second", 32'(busy_cnt), 32'd33);
      @(negedge clk);
      check("b2b_no_extra_busy", {31'd0, busy}, 32'd0);

      // Asynchronous reset mid-divide, between clock edges
      @(negedge clk);
      start = 1'b1; funct3 = F_DIVU; data1 = 32'd100; data2 = 32'd7;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 5; i++) @(negedge clk);
      check("arst_busy_before", {31'd0, busy}, 32'd1);
      check("arst_result_before", result, 32'd4);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      check("arst_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_rst_div", F_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34, 33);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
